// File: rtl/pdi_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pdi_decoder_pkg
// Description : Shared constants and helpers for the PDI stream decoder:
//               instruction opcodes, header bit positions, FSM encoding and
//               the instruction-field decode function.
// Revision    : 1.0 - initial release
// ============================================================================
package pdi_decoder_pkg;

    // Instruction opcodes carried in word[31:28]
    localparam logic [3:0] OP_ENC  = 4'h2;
    localparam logic [3:0] OP_DEC  = 4'h3;
    localparam logic [3:0] OP_KEY  = 4'h4;
    localparam logic [3:0] OP_SEED = 4'h5;

    // Instruction / header bit positions
    localparam int OP_MSB       = 31;
    localparam int OP_LSB       = 28;
    localparam int INSTR_KEYBIT = 27;
    localparam int HDR_DT_MSB   = 31;
    localparam int HDR_DT_LSB   = 28;
    localparam int HDR_EOI      = 26;
    localparam int HDR_EOT      = 25;
    localparam int HDR_LAST     = 24;
    localparam int HDR_LEN_MSB  = 15;

    // FSM state encoding
    localparam logic [1:0] S_INSTR = 2'd0;
    localparam logic [1:0] S_HDR   = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;

    typedef struct packed {
        logic decrypt;
        logic key_update;
        logic key_only;
        logic seed_update;
    } instr_fields_t;

    function automatic logic op_is_valid(input logic [3:0] op);
        return (op == OP_ENC) || (op == OP_DEC) || (op == OP_KEY) || (op == OP_SEED);
    endfunction

    // The key bit only modifies ENC/DEC; KEY always updates the key alone.
    function automatic instr_fields_t decode_instr(input logic [3:0] op, input logic key_bit);
        instr_fields_t f;
        f = '0;
        case (op)
            OP_ENC:  f.key_update = key_bit;
            OP_DEC:  begin f.decrypt = 1'b1; f.key_update = key_bit; end
            OP_KEY:  begin f.key_update = 1'b1; f.key_only = 1'b1; end
            OP_SEED: f.seed_update = 1'b1;
            default: f = '0;
        endcase
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pdi_decoder_seg_counter.sv
`default_nettype none
// ============================================================================
// Module      : pdi_seg_counter
// Description : Remaining-segment-length tracker. Holds the byte count still
//               owed by the current segment and derives, for the word about to
//               be accepted, the partial / last-of-segment flags and the
//               MSB-first valid-byte mask.
//   clk, rst   : clock, synchronous active-high reset
//   i_load     : load i_len into the remaining count (header accepted)
//   i_len      : segment length in bytes
//   i_step     : a data word is accepted; subtract min(rem, bytes/word)
//   o_partial  : current word carries fewer than a full word of bytes
//   o_last     : current word is the final word of the segment
//   o_mask     : valid-byte mask for the current word, MSB-first
// Revision    : 1.0 - initial release
// ============================================================================
module pdi_seg_counter #(
    parameter int BUS_SIZE = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_load,
    input  logic [15:0]             i_len,
    input  logic                    i_step,
    output logic                    o_partial,
    output logic                    o_last,
    output logic [BUS_SIZE/8-1:0]   o_mask
);

    localparam int         c_bytes_int = BUS_SIZE / 8;
    localparam logic [15:0] c_bytes    = 16'(c_bytes_int);

    logic [15:0] r_rem;
    logic [15:0] w_n;

    always_comb begin
        // n never exceeds rem, so the subtraction below cannot wrap
        w_n       = (r_rem < c_bytes) ? r_rem : c_bytes;
        o_partial = (r_rem < c_bytes);
        o_last    = (r_rem <= c_bytes);
        o_mask    = '0;
        for (int i = 0; i < c_bytes_int; i++) begin
            o_mask[c_bytes_int-1-i] = (16'(i) < w_n);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem <= '0;
        end else if (i_load) begin
            r_rem <= i_len;
        end else if (i_step) begin
            r_rem <= r_rem - w_n;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pdi_decoder.sv
`default_nettype none
// ============================================================================
// Module      : pdi_decoder
// Description : PDI input stream parser. Classifies each accepted word as an
//               instruction, segment header or data word, decodes its fields
//               and presents it in a one-entry slot to the mode controller.
//   pdi_data/pdi_valid/pdi_ready          : input word handshake
//   instruction_valid/header_valid/
//   data_in_valid + rdy_*_fetch           : slot handshakes to the controller
//   decrypt/key_update/key_only/seed_update : instruction fields
//   dtype/eoi/eot/length/seg_empty        : header fields
//   data_out/data_in_partial/
//   data_in_last_of_seg/sel_nibble        : data word and byte qualifiers
// Revision    : 1.0 - initial release
// ============================================================================
module pdi_decoder
    import pdi_decoder_pkg::*;
#(
    parameter int BUS_SIZE = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BUS_SIZE-1:0]   pdi_data,
    input  logic                  pdi_valid,
    output logic                  pdi_ready,
    output logic                  instruction_valid,
    output logic                  header_valid,
    output logic                  data_in_valid,
    input  logic                  rdy_instr_fetch,
    input  logic                  rdy_head_fetch,
    input  logic                  rdy_data_fetch,
    output logic                  decrypt,
    output logic                  key_update,
    output logic                  key_only,
    output logic                  seed_update,
    output logic [3:0]            dtype,
    output logic                  eoi,
    output logic                  eot,
    output logic [15:0]           length,
    output logic                  seg_empty,
    output logic [BUS_SIZE-1:0]   data_out,
    output logic                  data_in_partial,
    output logic                  data_in_last_of_seg,
    output logic [BUS_SIZE/8-1:0] sel_nibble
);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_instr_valid;
    logic                  r_hdr_valid;
    logic                  r_data_valid;
    instr_fields_t         r_instr;
    logic [3:0]            r_dtype;
    logic                  r_eoi;
    logic                  r_eot;
    logic [15:0]           r_length;
    logic                  r_seg_empty;
    logic                  r_seg_last;
    logic [BUS_SIZE-1:0]   r_data;
    logic                  r_partial;
    logic                  r_last_of_seg;
    logic [BUS_SIZE/8-1:0] r_mask;

    logic                  w_consume;
    logic                  w_accept;
    logic [3:0]            w_op;
    logic [15:0]           w_len;
    logic                  w_cnt_partial;
    logic                  w_cnt_last;
    logic [BUS_SIZE/8-1:0] w_cnt_mask;

    assign w_op  = pdi_data[OP_MSB:OP_LSB];
    assign w_len = pdi_data[HDR_LEN_MSB:0];

    // Only one slot flag is ever set, so at most one term is active.
    assign w_consume = (r_instr_valid & rdy_instr_fetch) |
                       (r_hdr_valid   & rdy_head_fetch)  |
                       (r_data_valid  & rdy_data_fetch);
    assign pdi_ready = ~(r_instr_valid | r_hdr_valid | r_data_valid) | w_consume;
    assign w_accept  = pdi_valid & pdi_ready;

    pdi_seg_counter #(
        .BUS_SIZE (BUS_SIZE)
    ) u_seg_counter (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_accept && (r_state == S_HDR)),
        .i_len     (w_len),
        .i_step    (w_accept && (r_state == S_DATA)),
        .o_partial (w_cnt_partial),
        .o_last    (w_cnt_last),
        .o_mask    (w_cnt_mask)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            case (r_state)
                S_INSTR: if (op_is_valid(w_op)) w_state_nxt = S_HDR;
                S_HDR: begin
                    if (w_len != 16'd0)             w_state_nxt = S_DATA;
                    else if (pdi_data[HDR_LAST])    w_state_nxt = S_INSTR;
                end
                S_DATA: if (w_cnt_last) w_state_nxt = r_seg_last ? S_INSTR : S_HDR;
                default: w_state_nxt = S_INSTR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_INSTR;
            r_instr_valid <= 1'b0;
            r_hdr_valid   <= 1'b0;
            r_data_valid  <= 1'b0;
            r_instr       <= '0;
            r_dtype       <= '0;
            r_eoi         <= 1'b0;
            r_eot         <= 1'b0;
            r_length      <= '0;
            r_seg_empty   <= 1'b0;
            r_seg_last    <= 1'b0;
            r_data        <= '0;
            r_partial     <= 1'b0;
            r_last_of_seg <= 1'b0;
            r_mask        <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_consume) begin
                r_instr_valid <= 1'b0;
                r_hdr_valid   <= 1'b0;
                r_data_valid  <= 1'b0;
            end
            // A new word overrides the consume clear above, so back-to-back
            // traffic keeps the slot full without a bubble.
            if (w_accept) begin
                case (r_state)
                    S_INSTR: begin
                        // Unknown opcodes are swallowed: slot stays empty.
                        if (op_is_valid(w_op)) begin
                            r_instr_valid <= 1'b1;
                            r_instr       <= decode_instr(w_op, pdi_data[INSTR_KEYBIT]);
                        end
                    end
                    S_HDR: begin
                        r_hdr_valid <= 1'b1;
                        r_dtype     <= pdi_data[HDR_DT_MSB:HDR_DT_LSB];
                        r_eoi       <= pdi_data[HDR_EOI];
                        r_eot       <= pdi_data[HDR_EOT];
                        r_seg_last  <= pdi_data[HDR_LAST];
                        r_length    <= w_len;
                        r_seg_empty <= (w_len == 16'd0);
                    end
                    S_DATA: begin
                        r_data_valid  <= 1'b1;
                        r_data        <= pdi_data;
                        r_partial     <= w_cnt_partial;
                        r_last_of_seg <= w_cnt_last;
                        r_mask        <= w_cnt_mask;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign instruction_valid   = r_instr_valid;
    assign header_valid        = r_hdr_valid;
    assign data_in_valid       = r_data_valid;
    assign decrypt             = r_instr.decrypt;
    assign key_update          = r_instr.key_update;
    assign key_only            = r_instr.key_only;
    assign seed_update         = r_instr.seed_update;
    assign dtype               = r_dtype;
    assign eoi                 = r_eoi;
    assign eot                 = r_eot;
    assign length              = r_length;
    assign seg_empty           = r_seg_empty;
    assign data_out            = r_data;
    assign data_in_partial     = r_partial;
    assign data_in_last_of_seg = r_last_of_seg;
    assign sel_nibble          = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_pdi_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pdi_decoder
// Description : Self-checking bench for pdi_decoder (BUS_SIZE = 32). A table
//               of one-word-per-cycle vectors with every fetch ready, followed
//               by hand-written backpressure and mid-segment reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pdi_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pdi_data;
    logic        pdi_valid;
    logic        pdi_ready;
    logic        instruction_valid, header_valid, data_in_valid;
    logic        rdy_instr_fetch, rdy_head_fetch, rdy_data_fetch;
    logic        decrypt, key_update, key_only, seed_update;
    logic [3:0]  dtype;
    logic        eoi, eot;
    logic [15:0] length;
    logic        seg_empty;
    logic [31:0] data_out;
    logic        data_in_partial, data_in_last_of_seg;
    logic [3:0]  sel_nibble;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pdi_decoder #(.BUS_SIZE(32)) dut (
        .clk(clk), .rst(rst),
        .pdi_data(pdi_data), .pdi_valid(pdi_valid), .pdi_ready(pdi_ready),
        .instruction_valid(instruction_valid), .header_valid(header_valid),
        .data_in_valid(data_in_valid),
        .rdy_instr_fetch(rdy_instr_fetch), .rdy_head_fetch(rdy_head_fetch),
        .rdy_data_fetch(rdy_data_fetch),
        .decrypt(decrypt), .key_update(key_update), .key_only(key_only),
        .seed_update(seed_update),
        .dtype(dtype), .eoi(eoi), .eot(eot), .length(length), .seg_empty(seg_empty),
        .data_out(data_out), .data_in_partial(data_in_partial),
        .data_in_last_of_seg(data_in_last_of_seg), .sel_nibble(sel_nibble)
    );

    typedef struct {
        logic [31:0] din;
        logic        iv, hv, dv;
        logic [3:0]  ins;   // {decrypt, key_update, key_only, seed_update}
        logic [3:0]  dt;
        logic        eoi, eot;
        logic [15:0] len;
        logic        se;
        logic [31:0] dout;
        logic        part, last;
        logic [3:0]  mask;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(input logic [31:0] din, input logic iv, hv, dv,
                                input logic [3:0] ins, dt, input logic e_oi, e_ot,
                                input logic [15:0] len, input logic se,
                                input logic [31:0] dout, input logic part, last,
                                input logic [3:0] mask);
        vec_t v;
        v.din = din; v.iv = iv; v.hv = hv; v.dv = dv; v.ins = ins; v.dt = dt;
        v.eoi = e_oi; v.eot = e_ot; v.len = len; v.se = se; v.dout = dout;
        v.part = part; v.last = last; v.mask = mask;
        return v;
    endfunction

    function automatic logic [67:0] pack_exp(input vec_t v);
        return {v.iv, v.hv, v.dv, v.ins, v.dt, v.eoi, v.eot, v.len, v.se,
                v.dout, v.part, v.last, v.mask};
    endfunction

    function automatic logic [67:0] pack_act();
        return {instruction_valid, header_valid, data_in_valid,
                decrypt, key_update, key_only, seed_update, dtype, eoi, eot,
                length, seg_empty, data_out, data_in_partial,
                data_in_last_of_seg, sel_nibble};
    endfunction

    task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Apply inputs, clock once, then sample 1 time unit after the edge.
    task automatic step(input logic [31:0] d, input logic v);
        pdi_data  = d;
        pdi_valid = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // One word per cycle, all fetch-ready. Field outputs hold between
        // loads of their own class. Header 0x1700_0005: dtype 1, eoi, eot,
        // last, length 5.
        //           din           iv hv dv ins      dt    eoi eot len    se dout          pt ls mask
        tbl[0]  = mk(32'h2000_0000,1,0,0,4'b0000,4'd0,0,0,16'd0,0,32'h0,        0,0,4'b0000);
        tbl[1]  = mk(32'h1700_0005,0,1,0,4'b0000,4'd1,1,1,16'd5,0,32'h0,        0,0,4'b0000);
        tbl[2]  = mk(32'hAAAA_AAAA,0,0,1,4'b0000,4'd1,1,1,16'd5,0,32'hAAAA_AAAA,0,0,4'b1111);
        tbl[3]  = mk(32'hBBBB_BBBB,0,0,1,4'b0000,4'd1,1,1,16'd5,0,32'hBBBB_BBBB,1,1,4'b1000);
        tbl[4]  = mk(32'h3800_0000,1,0,0,4'b1100,4'd1,1,1,16'd5,0,32'hBBBB_BBBB,1,1,4'b1000);
        tbl[5]  = mk(32'h5700_0000,0,1,0,4'b1100,4'd5,1,1,16'd0,1,32'hBBBB_BBBB,1,1,4'b1000);
        tbl[6]  = mk(32'hF000_0000,0,0,0,4'b1100,4'd5,1,1,16'd0,1,32'hBBBB_BBBB,1,1,4'b1000);
        tbl[7]  = mk(32'h5000_0000,1,0,0,4'b0001,4'd5,1,1,16'd0,1,32'hBBBB_BBBB,1,1,4'b1000);
        tbl[8]  = mk(32'h2000_0008,0,1,0,4'b0001,4'd2,0,0,16'd8,0,32'hBBBB_BBBB,1,1,4'b1000);
        tbl[9]  = mk(32'h1111_1111,0,0,1,4'b0001,4'd2,0,0,16'd8,0,32'h1111_1111,0,0,4'b1111);
        tbl[10] = mk(32'h2222_2222,0,0,1,4'b0001,4'd2,0,0,16'd8,0,32'h2222_2222,0,1,4'b1111);
        tbl[11] = mk(32'h2100_0004,0,1,0,4'b0001,4'd2,0,0,16'd4,0,32'h2222_2222,0,1,4'b1111);
        tbl[12] = mk(32'h3333_3333,0,0,1,4'b0001,4'd2,0,0,16'd4,0,32'h3333_3333,0,1,4'b1111);
        tbl[13] = mk(32'h4000_0000,1,0,0,4'b0110,4'd2,0,0,16'd4,0,32'h3333_3333,0,1,4'b1111);
        tbl[14] = mk(32'h2100_0003,0,1,0,4'b0110,4'd2,0,0,16'd3,0,32'h3333_3333,0,1,4'b1111);
        tbl[15] = mk(32'h4444_4444,0,0,1,4'b0110,4'd2,0,0,16'd3,0,32'h4444_4444,1,1,4'b1110);
        tbl[16] = mk(32'h3000_0000,1,0,0,4'b1000,4'd2,0,0,16'd3,0,32'h4444_4444,1,1,4'b1110);

        rst = 1'b1;
        pdi_data = '0; pdi_valid = 1'b0;
        rdy_instr_fetch = 1'b1; rdy_head_fetch = 1'b1; rdy_data_fetch = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk("reset_outputs", pack_act(), 68'd0);
        chk("reset_ready", 68'(pdi_ready), 68'd1);

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].din, 1'b1);
            chk($sformatf("vec%0d", i), pack_act(), pack_exp(tbl[i]));
        end

        // Backpressure: state is S_HDR after the DEC instruction above.
        step(32'h2100_000C, 1'b1);                     // len 12, last
        chk("bp_hdr", 68'({header_valid, length}), 68'({1'b1, 16'd12}));
        step(32'hD1D1_D1D1, 1'b1);
        chk("bp_d1", 68'({data_in_valid, data_out}), 68'({1'b1, 32'hD1D1_D1D1}));
        rdy_data_fetch = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(32'hD2D2_D2D2, 1'b1);
            chk($sformatf("bp_stall%0d", k),
                68'({pdi_ready, data_in_valid, data_out, data_in_last_of_seg, sel_nibble}),
                68'({1'b0, 1'b1, 32'hD1D1_D1D1, 1'b0, 4'b1111}));
        end
        rdy_data_fetch = 1'b1;
        #1;
        chk("bp_release_ready", 68'(pdi_ready), 68'd1);
        step(32'hD2D2_D2D2, 1'b1);
        chk("bp_d2_nobubble", 68'({data_in_valid, data_out, data_in_last_of_seg}),
            68'({1'b1, 32'hD2D2_D2D2, 1'b0}));
        step(32'hD3D3_D3D3, 1'b1);
        chk("bp_d3_last", 68'({data_in_valid, data_out, data_in_last_of_seg, sel_nibble}),
            68'({1'b1, 32'hD3D3_D3D3, 1'b1, 4'b1111}));
        step(32'h0, 1'b0);
        chk("bp_idle", 68'({instruction_valid, header_valid, data_in_valid}), 68'd0);

        // Reset after 1 of 3 data words.
        step(32'h2000_0000, 1'b1);
        chk("rst_seq_instr", 68'(instruction_valid), 68'd1);
        step(32'h2100_000C, 1'b1);
        step(32'hE1E1_E1E1, 1'b1);
        chk("rst_seq_d1", 68'({data_in_valid, data_out}), 68'({1'b1, 32'hE1E1_E1E1}));
        rst = 1'b1;
        step(32'h0, 1'b0);
        rst = 1'b0;
        chk("rst_mid_clear", pack_act(), 68'd0);
        step(32'h2000_0000, 1'b1);
        chk("rst_next_instr", 68'({instruction_valid, header_valid, data_in_valid, decrypt}),
            68'({1'b1, 1'b0, 1'b0, 1'b0}));
        step(32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
